// File: rtl/xf_sweep_ctrl_pkg.sv
// Shared definitions for the Xf sweep sequencer: state encoding and default widths/reset value.
package xf_sweep_ctrl_pkg;

  localparam int unsigned W_DEF    = 16;
  localparam int unsigned DW_DEF   = 16;
  localparam int unsigned XRST_DEF = 49;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;

endpackage

// File: rtl/xf_dwell_timer.sv
// Dwell timer: counts ce1ms ticks and flags the tick on which a sweep step is due.
// Ports:
//   clk, rst   clock, async active-high reset
//   ce_i       1 ms tick
//   clr_i      hold counter at zero (used while the sequencer is idle)
//   dwell_i    ticks per step; 0 behaves as 1
//   due_c_o    combinational: this ce_i completes a dwell period
module xf_dwell_timer #(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce_i,
  input  logic          clr_i,
  input  logic [DW-1:0] dwell_i,
  output logic          due_c_o
);

  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] last_c;

  // Terminal count is max(dwell,1)-1, so dwell 0 and 1 both step every tick.
  always_comb begin
    last_c = '0;
    if (dwell_i != '0) begin
      last_c = dwell_i - DW'(1);
    end
  end

  assign due_c_o = ce_i && (cnt_q == last_c);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ce_i) begin
      cnt_d = due_c_o ? '0 : cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/xf_sweep_ctrl.sv
// Xf sweep sequencer: steps the tone generator frequency word between latched
// bounds on 1 ms ticks, as a single ramp or a continuous triangle.
// Ports:
//   clk, rst            clock, async active-high reset
//   ce1ms_i             one-clk tick every 1 ms
//   start_i, stop_i     level controls; stop wins over start and over a due step
//   tri_i, dir_up_i     triangle mode, initial direction (latched/used at start)
//   xmin_i, xmax_i      bounds; xstep_i increment; dwell_i ms ticks per step
//   xf_o                frequency word; xf_stb_o pulses with every xf_o change
//   busy_o              sweep running; done_o single ramp finished; err_o start rejected
module xf_sweep_ctrl
  import xf_sweep_ctrl_pkg::*;
#(
  parameter int unsigned W    = W_DEF,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned XRST = XRST_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce1ms_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          tri_i,
  input  logic          dir_up_i,
  input  logic [W-1:0]  xmin_i,
  input  logic [W-1:0]  xmax_i,
  input  logic [W-1:0]  xstep_i,
  input  logic [DW-1:0] dwell_i,
  output logic [W-1:0]  xf_o,
  output logic          xf_stb_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  state_e        state_q, state_d;
  logic [W-1:0]  xf_q, xf_d;
  logic          xf_stb_q, xf_stb_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [W-1:0]  xmin_q, xmin_d;
  logic [W-1:0]  xmax_q, xmax_d;
  logic [W-1:0]  xstep_q, xstep_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          tri_q, tri_d;

  logic          due_c;
  logic          timer_clr_c;
  logic [W:0]    sum_c, diff_c;
  logic [W-1:0]  up_next_c, down_next_c;

  xf_dwell_timer #(.DW(DW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .ce_i    (ce1ms_i),
    .clr_i   (timer_clr_c),
    .dwell_i (dwell_q),
    .due_c_o (due_c)
  );

  // Clamped step candidates, one bit wider so overflow/borrow is visible.
  // At a bound they double as the reversal value: at Xmax, Xf-Xstep is
  // Xmax-Xstep, and at Xmin, Xf+Xstep is Xmin+Xstep.
  always_comb begin
    sum_c       = {1'b0, xf_q} + {1'b0, xstep_q};
    diff_c      = {1'b0, xf_q} - {1'b0, xstep_q};
    up_next_c   = (sum_c > {1'b0, xmax_q}) ? xmax_q : sum_c[W-1:0];
    down_next_c = (diff_c[W] || (diff_c[W-1:0] < xmin_q)) ? xmin_q : diff_c[W-1:0];
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    xf_d        = xf_q;
    xf_stb_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    xstep_d     = xstep_q;
    dwell_d     = dwell_q;
    tri_d       = tri_q;
    timer_clr_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        timer_clr_c = 1'b1;
        if (start_i && !stop_i) begin
          if ((xmin_i > xmax_i) || (xstep_i == '0)) begin
            err_d = 1'b1;
          end else begin
            xmin_d   = xmin_i;
            xmax_d   = xmax_i;
            xstep_d  = xstep_i;
            dwell_d  = dwell_i;
            tri_d    = tri_i;
            xf_stb_d = 1'b1;
            if (dir_up_i) begin
              state_d = ST_UP;
              xf_d    = xmin_i;
            end else begin
              state_d = ST_DOWN;
              xf_d    = xmax_i;
            end
          end
        end
      end

      ST_UP: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (due_c) begin
          if (xf_q == xmax_q) begin
            if (!tri_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d  = ST_DOWN;
              xf_d     = down_next_c;
              xf_stb_d = (down_next_c != xf_q);
            end
          end else begin
            xf_d     = up_next_c;
            xf_stb_d = (up_next_c != xf_q);
          end
        end
      end

      ST_DOWN: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (due_c) begin
          if (xf_q == xmin_q) begin
            if (!tri_q) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d  = ST_UP;
              xf_d     = up_next_c;
              xf_stb_d = (up_next_c != xf_q);
            end
          end else begin
            xf_d     = down_next_c;
            xf_stb_d = (down_next_c != xf_q);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      xf_q     <= W'(XRST);
      xf_stb_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      xmin_q   <= '0;
      xmax_q   <= '0;
      xstep_q  <= '0;
      dwell_q  <= '0;
      tri_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      xf_q     <= xf_d;
      xf_stb_q <= xf_stb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      xmin_q   <= xmin_d;
      xmax_q   <= xmax_d;
      xstep_q  <= xstep_d;
      dwell_q  <= dwell_d;
      tri_q    <= tri_d;
    end
  end

  assign xf_o     = xf_q;
  assign xf_stb_o = xf_stb_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_xf_sweep_ctrl.sv
// Bench for xf_sweep_ctrl: directed scenarios plus randomized traffic, checked
// against a reference that precomputes each sweep's Xf step list from the bounds.
module tb_xf_sweep_ctrl;

  logic        clk;
  logic        rst;
  logic        ce1ms_i, start_i, stop_i, tri_i, dir_up_i;
  logic [15:0] xmin_i, xmax_i, xstep_i, dwell_i;
  logic [15:0] xf_o;
  logic        xf_stb_o, busy_o, done_o, err_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [15:0] xf;
    logic        stb;
    logic        busy;
    logic        done;
    logic        err;
  } obs_t;

  typedef struct {
    int xf;
    bit done;
  } step_t;

  // Reference state: the remaining steps of the current sweep, precomputed at start.
  bit    m_busy;
  int    m_xf;
  int    m_tick;
  int    m_d;
  step_t m_q[$];

  xf_sweep_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .ce1ms_i  (ce1ms_i),
    .start_i  (start_i),
    .stop_i   (stop_i),
    .tri_i    (tri_i),
    .dir_up_i (dir_up_i),
    .xmin_i   (xmin_i),
    .xmax_i   (xmax_i),
    .xstep_i  (xstep_i),
    .dwell_i  (dwell_i),
    .xf_o     (xf_o),
    .xf_stb_o (xf_stb_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.xf = xf_o; o.stb = xf_stb_o; o.busy = busy_o; o.done = done_o; o.err = err_o;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("xf=%0d stb=%b busy=%b done=%b err=%b", o.xf, o.stb, o.busy, o.done, o.err);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_xf = 49; m_tick = 0; m_d = 1; m_q.delete();
  endtask

  // Whole sweep as a list of Xf values; a single ramp ends in a done entry.
  task automatic build_steps(input bit tr, input bit up, input int mn, input int mx, input int stp);
    int x;
    bit goes_up;
    x = up ? mn : mx;
    goes_up = up;
    m_q.delete();
    for (int i = 0; i < 400; i++) begin
      step_t s;
      s.done = 0;
      if (goes_up) begin
        if (x == mx) begin
          if (!tr) begin s.done = 1; s.xf = x; m_q.push_back(s); break; end
          goes_up = 0;
          x = (mx - stp < mn) ? mn : mx - stp;
        end else begin
          x = (x + stp > mx) ? mx : x + stp;
        end
      end else begin
        if (x == mn) begin
          if (!tr) begin s.done = 1; s.xf = x; m_q.push_back(s); break; end
          goes_up = 1;
          x = (mn + stp > mx) ? mx : mn + stp;
        end else begin
          x = (x - stp < mn) ? mn : x - stp;
        end
      end
      s.xf = x;
      m_q.push_back(s);
    end
  endtask

  // Expected outputs after one clock edge with the given controls.
  task automatic model_clk(input bit st, input bit sp, input bit ce, output obs_t o);
    step_t e;
    o.stb = 0; o.done = 0; o.err = 0;
    if (!m_busy) begin
      if (st && !sp) begin
        if ((int'(xmin_i) > int'(xmax_i)) || (xstep_i == 0)) begin
          o.err = 1;
        end else begin
          build_steps(tri_i, dir_up_i, int'(xmin_i), int'(xmax_i), int'(xstep_i));
          m_busy = 1;
          m_tick = 0;
          m_d    = (dwell_i == 0) ? 1 : int'(dwell_i);
          m_xf   = dir_up_i ? int'(xmin_i) : int'(xmax_i);
          o.stb  = 1;
        end
      end
    end else if (sp) begin
      m_busy = 0;
    end else if (ce) begin
      m_tick++;
      if (m_tick == m_d) begin
        m_tick = 0;
        if (m_q.size() > 0) begin
          e = m_q.pop_front();
          if (e.done) begin
            m_busy = 0;
            o.done = 1;
          end else begin
            o.stb = (e.xf != m_xf);
            m_xf  = e.xf;
          end
        end
      end
    end
    o.xf   = 16'(m_xf);
    o.busy = m_busy;
  endtask

  // Drive one cycle of controls, advance the reference, settle past the edge.
  task automatic cycle(input bit st, input bit sp, input bit ce, output obs_t e);
    start_i = st; stop_i = sp; ce1ms_i = ce;
    @(posedge clk);
    model_clk(st, sp, ce, e);
    #1;
  endtask

  task automatic set_cfg(input int mn, input int mx, input int stp, input int dw, input bit tr, input bit up);
    xmin_i = 16'(mn); xmax_i = 16'(mx); xstep_i = 16'(stp); dwell_i = 16'(dw);
    tri_i = tr; dir_up_i = up;
  endtask

  task automatic test_reset();
    obs_t e;
    e.xf = 16'd49; e.stb = 0; e.busy = 0; e.done = 0; e.err = 0;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (sample() !== e) begin
        miscompares++;
        $display("FAIL reset_state: got %s, expected %s", fmt(sample()), fmt(e));
      end
    end
    rst = 0;
    model_reset();
    cycle(0, 0, 1, e);
    vectors++;
    if (sample() !== e) begin
      miscompares++;
      $display("FAIL reset_idle: got %s, expected %s", fmt(sample()), fmt(e));
    end
  endtask

  task automatic test_single_up();
    obs_t e;
    int got[$];
    int exp_seq[4];
    bit seen_done;
    exp_seq = '{10, 14, 18, 20};
    seen_done = 0;
    set_cfg(10, 20, 4, 2, 0, 1);
    cycle(1, 0, 0, e);
    for (int c = 0; c < 200 && !seen_done; c++) begin
      vectors++;
      if (sample() !== e) begin
        miscompares++;
        $display("FAIL single_up cyc %0d: got %s, expected %s", c, fmt(sample()), fmt(e));
      end
      if (xf_stb_o) got.push_back(int'(xf_o));
      if (done_o) seen_done = 1;
      if (!seen_done) cycle(0, 0, 1'($urandom_range(0, 1)), e);
    end
    vectors++;
    if (!seen_done || got.size() != 4) begin
      miscompares++;
      $display("FAIL single_up_seq: got %0d changes done=%b, expected 4 changes done=1", got.size(), seen_done);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (got[i] != exp_seq[i]) begin
          miscompares++;
          $display("FAIL single_up_seq[%0d]: got %0d, expected %0d", i, got[i], exp_seq[i]);
        end
      end
    end
    cycle(0, 0, 1, e);
    vectors++;
    if (busy_o !== 1'b0 || sample() !== e) begin
      miscompares++;
      $display("FAIL single_up_idle: got %s, expected %s", fmt(sample()), fmt(e));
    end
  endtask

  task automatic test_triangle_down();
    obs_t e;
    int got[$];
    int exp_seq[6];
    exp_seq = '{9, 6, 5, 8, 9, 6};
    set_cfg(5, 9, 3, 0, 1, 0);
    cycle(1, 0, 0, e);
    for (int c = 0; c < 100 && got.size() < 6; c++) begin
      vectors++;
      if (sample() !== e) begin
        miscompares++;
        $display("FAIL triangle cyc %0d: got %s, expected %s", c, fmt(sample()), fmt(e));
      end
      if (xf_stb_o) got.push_back(int'(xf_o));
      if (got.size() < 6) cycle(0, 0, 1'($urandom_range(0, 1)), e);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (i >= got.size() || got[i] != exp_seq[i]) begin
        miscompares++;
        $display("FAIL triangle_seq[%0d]: got %0d, expected %0d", i, (i < got.size()) ? got[i] : -1, exp_seq[i]);
      end
    end
    cycle(0, 1, 0, e);
    vectors++;
    if (sample() !== e) begin
      miscompares++;
      $display("FAIL triangle_stop: got %s, expected %s", fmt(sample()), fmt(e));
    end
  endtask

  task automatic test_reject();
    obs_t e;
    logic [15:0] xf_before;
    xf_before = xf_o;
    set_cfg(30, 20, 2, 1, 0, 1);
    cycle(1, 0, 0, e);
    vectors++;
    if (sample() !== e || err_o !== 1'b1 || xf_o !== xf_before) begin
      miscompares++;
      $display("FAIL reject_range: got %s, expected %s", fmt(sample()), fmt(e));
    end
    cycle(0, 0, 0, e);
    vectors++;
    if (sample() !== e || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reject_pulse: got %s, expected %s", fmt(sample()), fmt(e));
    end
    set_cfg(20, 30, 0, 1, 0, 1);
    cycle(1, 0, 0, e);
    vectors++;
    if (sample() !== e || err_o !== 1'b1 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reject_step0: got %s, expected %s", fmt(sample()), fmt(e));
    end
    cycle(0, 0, 0, e);
    vectors++;
    if (sample() !== e) begin
      miscompares++;
      $display("FAIL reject_after: got %s, expected %s", fmt(sample()), fmt(e));
    end
  endtask

  task automatic test_stop_precedence();
    obs_t e;
    logic [15:0] xf_before;
    int n;
    set_cfg(10, 40, 5, 3, 1, 1);
    cycle(1, 0, 0, e);
    n = 0;
    while (m_tick != m_d - 1 && n < 20) begin
      vectors++;
      if (sample() !== e) begin
        miscompares++;
        $display("FAIL stop_prep: got %s, expected %s", fmt(sample()), fmt(e));
      end
      cycle(0, 0, 1, e);
      n++;
    end
    xf_before = xf_o;
    cycle(0, 1, 1, e);
    vectors++;
    if (sample() !== e || xf_o !== xf_before || xf_stb_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_vs_step: got %s, expected %s", fmt(sample()), fmt(e));
    end
    cycle(1, 1, 1, e);
    vectors++;
    if (sample() !== e || busy_o !== 1'b0 || xf_stb_o !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_vs_start: got %s, expected %s", fmt(sample()), fmt(e));
    end
  endtask

  task automatic test_saturation();
    obs_t e;
    int got[$];
    bit seen_done;
    seen_done = 0;
    set_cfg(30000, 65535, 40000, 1, 0, 1);
    cycle(1, 0, 0, e);
    for (int c = 0; c < 50 && !seen_done; c++) begin
      vectors++;
      if (sample() !== e) begin
        miscompares++;
        $display("FAIL saturation cyc %0d: got %s, expected %s", c, fmt(sample()), fmt(e));
      end
      if (xf_stb_o) got.push_back(int'(xf_o));
      if (done_o) seen_done = 1;
      if (!seen_done) cycle(0, 0, 1, e);
    end
    vectors++;
    if (!seen_done || got.size() != 2 || got[0] != 30000 || got[1] != 65535) begin
      miscompares++;
      $display("FAIL saturation_seq: got %0d changes (first %0d last %0d) done=%b, expected 30000,65535 done=1",
               got.size(), (got.size() > 0) ? got[0] : -1, (got.size() > 0) ? got[got.size()-1] : -1, seen_done);
    end
  endtask

  task automatic test_start_held();
    obs_t e;
    bit after_done;
    int restarts;
    after_done = 0;
    restarts = 0;
    set_cfg(3, 7, 2, 1, 0, 1);
    for (int c = 0; c < 30; c++) begin
      cycle(1, 0, 1, e);
      vectors++;
      if (sample() !== e) begin
        miscompares++;
        $display("FAIL start_held cyc %0d: got %s, expected %s", c, fmt(sample()), fmt(e));
      end
      if (after_done) begin
        vectors++;
        if (!(xf_stb_o === 1'b1 && xf_o === 16'd3 && busy_o === 1'b1)) begin
          miscompares++;
          $display("FAIL start_held_restart: got %s, expected xf=3 stb=1 busy=1", fmt(sample()));
        end
        restarts++;
      end
      after_done = (done_o === 1'b1);
    end
    vectors++;
    if (restarts < 2) begin
      miscompares++;
      $display("FAIL start_held_count: got %0d restarts, expected at least 2", restarts);
    end
    cycle(0, 1, 0, e);
  endtask

  task automatic test_reset_midsweep();
    obs_t e;
    e.xf = 16'd49; e.stb = 0; e.busy = 0; e.done = 0; e.err = 0;
    set_cfg(100, 200, 7, 1, 1, 1);
    cycle(1, 0, 0, e);
    for (int c = 0; c < 4; c++) cycle(0, 0, 1, e);
    ce1ms_i = 1;
    #2 rst = 1;
    #1;
    e.xf = 16'd49; e.stb = 0; e.busy = 0; e.done = 0; e.err = 0;
    vectors++;
    if (sample() !== e) begin
      miscompares++;
      $display("FAIL reset_async: got %s, expected %s", fmt(sample()), fmt(e));
    end
    @(posedge clk); #1;
    vectors++;
    if (sample() !== e) begin
      miscompares++;
      $display("FAIL reset_held: got %s, expected %s", fmt(sample()), fmt(e));
    end
    rst = 0;
    model_reset();
    cycle(0, 0, 1, e);
    vectors++;
    if (sample() !== e || xf_stb_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got %s, expected %s", fmt(sample()), fmt(e));
    end
  endtask

  task automatic test_random();
    obs_t e;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        set_cfg($urandom_range(60000, 65535), $urandom_range(60000, 65535),
                $urandom_range(0, 4000), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        set_cfg($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 6),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      cycle(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), e);
      vectors++;
      if (sample() !== e) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %s, expected %s", c, fmt(sample()), fmt(e));
      end
    end
  endtask

  initial begin
    rst = 1;
    ce1ms_i = 0; start_i = 0; stop_i = 0; tri_i = 0; dir_up_i = 0;
    xmin_i = 0; xmax_i = 0; xstep_i = 0; dwell_i = 0;
    model_reset();
    test_reset();
    test_single_up();
    test_triangle_down();
    test_reject();
    test_stop_precedence();
    test_saturation();
    test_start_held();
    test_reset_midsweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xf_sweep_ctrl.md
Name: xf_sweep_ctrl

Overview:
- Sequencer that drives the frequency word Xf of the phase-accumulator tone generator.
- Steps Xf between programmable bounds on 1 ms ticks: single up/down ramp, or continuous triangle sweep.
- Sits between the button/config logic and the generator's Xf input; replaces manual button stepping when a sweep is running.

Parameters:
- W, 16, width of Xf, Xmin, Xmax, Xstep.
- DW, 16, width of the dwell count (in ms ticks).
- XRST, 49, Xf value after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ce1ms  in  1  one-clk tick every 1 ms
- start  in  1  level; sampled every clk; begins sweep when IDLE
- stop  in  1  level; aborts sweep
- tri  in  1  0 = single ramp, 1 = continuous triangle
- dir_up  in  1  initial direction (1 = from Xmin upward)
- Xmin  in  W  lower bound
- Xmax  in  W  upper bound
- Xstep  in  W  increment per step
- dwell  in  DW  ms ticks per step; 0 is treated as 1
- Xf  out  W  frequency word to generator
- Xf_stb  out  1  one-clk pulse in the cycle Xf takes a new value
- busy  out  1  high in UP/DOWN
- done  out  1  one-clk pulse when a single ramp completes
- err  out  1  one-clk pulse when start is rejected

Behaviour:
- Reset (async, any time, including mid-sweep) sets:
  - State IDLE.
  - Xf = XRST; Xf_stb, busy, done, err = 0.
  - Dwell counter = 0; latched config = 0.
- States: IDLE, UP, DOWN.
- IDLE, start=1 and stop=0:
  - If Xmin > Xmax or Xstep == 0: err=1 for one clk, stay IDLE, Xf unchanged.
  - Otherwise latch Xmin, Xmax, Xstep, dwell, tri.
  - Next clk: Xf = Xmin (state UP) if dir_up, else Xf = Xmax (state DOWN); Xf_stb=1; dwell counter cleared.
- Inputs other than stop/rst are ignored while busy; config changes take effect only at the next start.
- UP/DOWN: the dwell counter increments on each ce1ms. A step is due on the ce1ms where counter == max(dwell,1)-1; the counter then clears.
- Step in UP (sum computed in W+1 bits, no wrap):
  - If Xf == Xmax:
    - tri=0: go IDLE, done=1, Xf held.
    - tri=1: go DOWN, Xf = max(Xmax-Xstep, Xmin).
  - Else Xf = min(Xf+Xstep, Xmax).
- Step in DOWN: mirror image of UP.
  - Difference checked for borrow before compare; clamps at Xmin.
  - At Xmin: tri=0 gives done; tri=1 reverses to UP.
- Timing: Xf, Xf_stb and done register one clk after the due ce1ms. Xf_stb accompanies every Xf change; no Xf_stb on a done without change.
- Degenerate range Xmin == Xmax:
  - tri=1: Xf stays at Xmin; no Xf_stb after the initial load.
  - tri=0: done on the first step.
- stop=1 in UP/DOWN: IDLE next clk, Xf held, no done, no Xf_stb. stop beats a simultaneous step or a simultaneous start.
- start held high after done: a new sweep begins on the clk after the return to IDLE (level-sensitive). The bench must cover this.
- busy = (state != IDLE), registered.

Decomposition:
- Shared package/include (alongside the existing CONST_XY definitions):
  - State encoding constants ST_IDLE, ST_UP, ST_DOWN.
  - Default XRST.
- One natural sub-module: xf_dwell_timer (DW-bit ce1ms counter with clear and a "due" output).
- Clamp/step arithmetic stays inline.

Test Plan:
- Reset mid-sweep: assert rst asynchronously during UP -> Xf=49, busy=0, no Xf_stb on the same or the next clk.
- Single up ramp: Xmin=10, Xmax=20, Xstep=4, dwell=2, tri=0, dir_up=1 -> Xf sequence 10,14,18,20.
  - One change every 2 ms; done pulses 2 ms after reaching 20; busy drops.
- Triangle down start: Xmin=5, Xmax=9, Xstep=3, dwell=0, tri=1, dir_up=0 -> Xf 9,6,5,8,9,6,...
  - Steps every 1 ms; no done.
- Rejection: Xmin=30, Xmax=20, start -> err one clk, Xf unchanged. Then Xstep=0 with a valid range -> err again.
- Stop precedence: stop asserted on the same clk as a due ce1ms in UP -> IDLE, Xf unchanged, no Xf_stb, no done.
- Saturation: W=16, Xmax=65535, Xstep=40000, Xmin=30000, up -> Xf 30000,65535 (no wrap), then done.
